draw_frame_manager: RTL and testbench

Downstream consumer of all draw sources (starfield, sprites, HUD) on the shared draw-manager bus. Once per frame, optionally clears the back framebuffer, then grants the bus to each source in ascending ID order. Each accepted pixel becomes a framebuffer write. At frame end it swaps front and back buffers.

---
 rtl/draw_pkg.sv | 18 +
 rtl/draw_pixel_stage.sv | 43 ++++
 rtl/draw_frame_manager.sv | 130 +++++++++++++
 tb/tb_draw_frame_manager.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// draw_pkg: shared state encoding, native framebuffer geometry and draw-source IDs
package draw_pkg;
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SERVE_WAIT,
    SERVE_ACTIVE,
    NEXT,
    SWAP
  } dm_state_t;
  localparam int NATIVE_DRAW_WIDTH  = 640;
  localparam int NATIVE_DRAW_HEIGHT = 480;
  localparam int FB_ADDR_W          = $clog2(NATIVE_DRAW_WIDTH * NATIVE_DRAW_HEIGHT);
  localparam int STARFIELD_ID       = 0;
  localparam int SPRITE_ID          = 1;
  localparam int HUD_ID             = 2;
  localparam int DEBUG_ID           = 3;
endpackage

// File: rtl/draw_pixel_stage.sv
// draw_pixel_stage: bounds check, linear address and output register for accepted pixels
module draw_pixel_stage
  import draw_pkg::*;
#(
  parameter int COLOR_DEPTH = 9,
  parameter int DRAW_WIDTH  = NATIVE_DRAW_WIDTH,
  parameter int DRAW_HEIGHT = NATIVE_DRAW_HEIGHT,
  parameter int AW          = FB_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_i,
  input  logic                   transparent_i,
  input  logic [COLOR_DEPTH-1:0] color_i,
  input  logic signed [31:0]     x_i,
  input  logic signed [31:0]     y_i,
  output logic                   we_o,
  output logic [AW-1:0]          addr_o,
  output logic [COLOR_DEPTH-1:0] data_o
);
  localparam logic [31:0] W = 32'(DRAW_WIDTH);
  logic [31:0] y_w;
  logic        we_d;
  logic [AW-1:0] addr_d;
  // y*DRAW_WIDTH as a sum of shifted copies of y, one per set bit of the width
  always_comb begin
    y_w = '0;
    for (int k = 0; k < 32; k++) y_w = W[k] ? y_w + (y_i << k) : y_w;
    we_d = valid_i && !transparent_i && x_i >= 0 && x_i < DRAW_WIDTH && y_i >= 0 && y_i < DRAW_HEIGHT;
    addr_d = AW'(y_w + x_i);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      we_o   <= 1'b0;
      addr_o <= '0;
      data_o <= '0;
    end else begin
      we_o   <= we_d;
      addr_o <= addr_d;
      data_o <= color_i;
    end
  end
endmodule

// File: rtl/draw_frame_manager.sv
// draw_frame_manager: per-frame clear, round-robin source grants and front/back buffer swap
module draw_frame_manager
  import draw_pkg::*;
#(
  parameter int                   NUM_SOURCES  = 4,
  parameter int                   COLOR_DEPTH  = 9,
  parameter int                   DRAW_WIDTH   = NATIVE_DRAW_WIDTH,
  parameter int                   DRAW_HEIGHT  = NATIVE_DRAW_HEIGHT,
  parameter logic [COLOR_DEPTH-1:0] BG_COLOR   = '0,
  parameter bit                   CLEAR_EN     = 1'b1,
  parameter int                   WAIT_TIMEOUT = 1024,
  localparam int SEL_W = NUM_SOURCES > 1 ? $clog2(NUM_SOURCES) : 1,
  localparam int AW    = $clog2(DRAW_WIDTH * DRAW_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame,
  output logic [SEL_W-1:0]       write_source_sel,
  output logic                   write_awaited,
  input  logic                   write_active,
  input  logic [COLOR_DEPTH-1:0] write_color_data,
  input  logic                   write_transparent,
  input  logic signed [31:0]     write_x_addr,
  input  logic signed [31:0]     write_y_addr,
  output logic                   fb_we,
  output logic [AW-1:0]          fb_addr,
  output logic [COLOR_DEPTH-1:0] fb_data,
  output logic                   fb_back_sel,
  output logic                   frame_done,
  output logic                   frame_overrun,
  output logic                   source_timeout
);
  localparam int WTW = $clog2(WAIT_TIMEOUT) + 1;
  localparam dm_state_t START = CLEAR_EN ? CLEAR : SERVE_WAIT;
  dm_state_t        state_q, state_d;
  logic [SEL_W-1:0] src_q, src_d;
  logic [AW-1:0]    clr_q, clr_d;
  logic [WTW-1:0]   wait_q, wait_d;
  logic pend_q, pend_d, back_q, back_d, done_q, done_d, ovr_q, ovr_d, to_q, to_d;
  logic pix_we;
  logic [AW-1:0] pix_addr;
  logic [COLOR_DEPTH-1:0] pix_data;
  logic clearing;
  assign clearing         = state_q == CLEAR;
  assign write_awaited    = state_q == SERVE_WAIT || state_q == SERVE_ACTIVE;
  assign write_source_sel = src_q;
  assign fb_we            = clearing || pix_we;
  assign fb_addr          = clearing ? clr_q : pix_addr;
  assign fb_data          = clearing ? BG_COLOR : pix_data;
  assign fb_back_sel      = back_q;
  assign frame_done       = done_q;
  assign frame_overrun    = ovr_q;
  assign source_timeout   = to_q;
  draw_pixel_stage #(
    .COLOR_DEPTH(COLOR_DEPTH),
    .DRAW_WIDTH (DRAW_WIDTH),
    .DRAW_HEIGHT(DRAW_HEIGHT),
    .AW         (AW)
  ) u_pix (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (write_awaited && write_active),
    .transparent_i(write_transparent),
    .color_i      (write_color_data),
    .x_i          (write_x_addr),
    .y_i          (write_y_addr),
    .we_o         (pix_we),
    .addr_o       (pix_addr),
    .data_o       (pix_data)
  );
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    clr_d   = clr_q;
    wait_d  = '0;
    ovr_d   = frame && state_q != IDLE;
    pend_d  = pend_q || ovr_d;
    back_d  = back_q;
    done_d  = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      IDLE: state_d = frame ? START : IDLE;
      CLEAR: begin
        clr_d   = clr_q == AW'(DRAW_WIDTH * DRAW_HEIGHT - 1) ? '0 : clr_q + 1'b1;
        state_d = clr_q == AW'(DRAW_WIDTH * DRAW_HEIGHT - 1) ? SERVE_WAIT : CLEAR;
      end
      SERVE_WAIT: begin
        to_d    = !write_active && wait_q == WTW'(WAIT_TIMEOUT - 1);
        state_d = write_active ? SERVE_ACTIVE : to_d ? NEXT : SERVE_WAIT;
        wait_d  = write_active || to_d ? '0 : wait_q + 1'b1;
      end
      SERVE_ACTIVE: state_d = write_active ? SERVE_ACTIVE : NEXT;
      NEXT: begin
        state_d = src_q == SEL_W'(NUM_SOURCES - 1) ? SWAP : SERVE_WAIT;
        src_d   = src_q == SEL_W'(NUM_SOURCES - 1) ? src_q : src_q + 1'b1;
      end
      SWAP: if (!pix_we) begin
        back_d  = !back_q;
        done_d  = 1'b1;
        state_d = pend_d ? START : IDLE;
        pend_d  = 1'b0;
        src_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      clr_q   <= '0;
      wait_q  <= '0;
      pend_q  <= 1'b0;
      back_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      clr_q   <= clr_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
      back_q  <= back_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
    end
  end
endmodule

// File: tb/tb_draw_frame_manager.sv
// tb_draw_frame_manager: directed checks on a 640x480 no-clear instance (a) and an 8x4 clearing instance (b)
module tb_draw_frame_manager;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_a = 1'b0, frame_b = 1'b0;
  logic active = 1'b0, transp = 1'b0;
  logic [8:0] color = '0;
  logic [31:0] x = '0, y = '0;
  logic [1:0] sel_a, sel_b;
  logic aw_a, aw_b, we_a, we_b, back_a, back_b, done_a, done_b, ovr_a, ovr_b, to_a, to_b;
  logic [18:0] addr_a;
  logic [4:0] addr_b;
  logic [8:0] data_a, data_b;
  int checks = 0, failures = 0;
  logic seen;
  always #5 clk = ~clk;
  draw_frame_manager #(.CLEAR_EN(1'b0), .WAIT_TIMEOUT(16)) dut_a (
    .clk(clk), .reset(reset), .frame(frame_a), .write_source_sel(sel_a), .write_awaited(aw_a),
    .write_active(active), .write_color_data(color), .write_transparent(transp),
    .write_x_addr(x), .write_y_addr(y), .fb_we(we_a), .fb_addr(addr_a), .fb_data(data_a),
    .fb_back_sel(back_a), .frame_done(done_a), .frame_overrun(ovr_a), .source_timeout(to_a));
  draw_frame_manager #(.DRAW_WIDTH(8), .DRAW_HEIGHT(4), .BG_COLOR(9'h0AA), .CLEAR_EN(1'b1), .WAIT_TIMEOUT(16)) dut_b (
    .clk(clk), .reset(reset), .frame(frame_b), .write_source_sel(sel_b), .write_awaited(aw_b),
    .write_active(active), .write_color_data(color), .write_transparent(transp),
    .write_x_addr(x), .write_y_addr(y), .fb_we(we_b), .fb_addr(addr_b), .fb_data(data_b),
    .fb_back_sel(back_b), .frame_done(done_b), .frame_overrun(ovr_b), .source_timeout(to_b));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send2(input int id);
    chk("grant_sel", 32'(sel_a), 32'(id));
    chk("grant_awaited", 32'(aw_a), 1);
    active = 1'b1; transp = 1'b0; x = 32'(id); y = 0; color = 9'(id + 1);
    step();
    chk("src_pix0_we", 32'(we_a), 1);
    chk("src_pix0_addr", 32'(addr_a), 32'(id));
    x = 32'(id + 100);
    step();
    chk("src_pix1_addr", 32'(addr_a), 32'(id + 100));
    active = 1'b0;
    step();
    chk("gap_awaited", 32'(aw_a), 0);
    step();
  endtask
  initial begin
    step(); step();
    reset = 1'b0;
    chk("rst_we_a", 32'(we_a), 0);
    chk("rst_we_b", 32'(we_b), 0);
    chk("rst_aw_a", 32'(aw_a), 0);
    chk("rst_back_a", 32'(back_a), 0);
    chk("rst_sel_a", 32'(sel_a), 0);
    chk("rst_done_a", 32'(done_a), 0);
    frame_b = 1'b1;
    step();
    frame_b = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("clr_we", 32'(we_b), 1);
      chk("clr_addr", 32'(addr_b), 32'(i));
      chk("clr_data", 32'(data_b), 32'h0AA);
      step();
    end
    chk("clr_we_after", 32'(we_b), 0);
    chk("clr_then_grant", 32'(aw_b), 1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      seen = done_b;
    end
    chk("b_frame_done_seen", 32'(seen), 1);
    chk("b_back_sel", 32'(back_b), 1);
    frame_a = 1'b1;
    step();
    frame_a = 1'b0;
    chk("a_grant0_aw", 32'(aw_a), 1);
    chk("a_grant0_sel", 32'(sel_a), 0);
    active = 1'b1; x = 5; y = 2; color = 9'h1FF;
    step();
    chk("pix_5_2_we", 32'(we_a), 1);
    chk("pix_5_2_addr", 32'(addr_a), 1285);
    chk("pix_5_2_data", 32'(data_a), 32'h1FF);
    x = 639; y = 479; color = 9'h123;
    step();
    chk("pix_corner_we", 32'(we_a), 1);
    chk("pix_corner_addr", 32'(addr_a), 307199);
    chk("pix_corner_data", 32'(data_a), 32'h123);
    x = 640; y = 0;
    step();
    chk("pix_x640_we", 32'(we_a), 0);
    transp = 1'b1; x = 10; y = 10;
    step();
    chk("pix_transp_we", 32'(we_a), 0);
    transp = 1'b0; x = 32'hFFFF_FFFF; y = 3;
    step();
    chk("pix_negx_we", 32'(we_a), 0);
    active = 1'b0;
    step();
    chk("a_gap0_aw", 32'(aw_a), 0);
    step();
    chk("a_grant1_sel", 32'(sel_a), 1);
    chk("a_grant1_aw", 32'(aw_a), 1);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      seen = seen | to_a;
    end
    chk("no_early_timeout", 32'(seen), 0);
    step();
    chk("timeout_pulse", 32'(to_a), 1);
    chk("timeout_aw_drop", 32'(aw_a), 0);
    step();
    chk("timeout_single", 32'(to_a), 0);
    send2(2);
    send2(3);
    chk("swap_no_done_yet", 32'(done_a), 0);
    step();
    chk("a_frame_done", 32'(done_a), 1);
    chk("a_back_sel_1", 32'(back_a), 1);
    step();
    chk("a_done_single", 32'(done_a), 0);
    frame_a = 1'b1;
    step();
    frame_a = 1'b0;
    send2(0);
    frame_a = 1'b1;
    step();
    frame_a = 1'b0;
    chk("overrun_1", 32'(ovr_a), 1);
    step();
    chk("overrun_1_single", 32'(ovr_a), 0);
    send2(1);
    frame_a = 1'b1;
    step();
    frame_a = 1'b0;
    chk("overrun_2", 32'(ovr_a), 1);
    send2(2);
    send2(3);
    step();
    chk("a2_frame_done", 32'(done_a), 1);
    chk("a2_back_sel_0", 32'(back_a), 0);
    chk("pending_restart_aw", 32'(aw_a), 1);
    chk("pending_restart_sel", 32'(sel_a), 0);
    frame_b = 1'b1; active = 1'b1; x = 1; y = 1;
    step();
    frame_b = 1'b0;
    chk("pre_rst_we_a", 32'(we_a), 1);
    chk("pre_rst_addr_a", 32'(addr_a), 641);
    chk("pre_rst_we_b", 32'(we_b), 1);
    reset = 1'b1; frame_a = 1'b1;
    step();
    chk("mid_rst_we_a", 32'(we_a), 0);
    chk("mid_rst_we_b", 32'(we_b), 0);
    chk("mid_rst_aw_a", 32'(aw_a), 0);
    chk("mid_rst_back_a", 32'(back_a), 0);
    chk("mid_rst_back_b", 32'(back_b), 0);
    chk("mid_rst_done_a", 32'(done_a), 0);
    chk("mid_rst_ovr_a", 32'(ovr_a), 0);
    reset = 1'b0; frame_a = 1'b0; active = 1'b0;
    step();
    chk("no_pending_after_rst", 32'(aw_a), 0);
    step();
    chk("still_idle_after_rst", 32'(aw_a), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
